scramble_id_sequence_emitter: RTL and testbench
===============================================

// Module: scramble_id_sequence_emitter
// PURPOSE
//  Serialises a 40-bit frame {IDENTIFIER[7:0], sequence[31:0]}, MSB first, as a 10-bit level stream for video insertion.
//  Each bit lasts BIT_PERIOD clocks and is coded as LEVEL_HIGH (1) or LEVEL_LOW (0).
//  The receiver slices bits against mid-scale 512.
//  Sits after the scrambler key source; output feeds the video sample mux.
//  Contains the identifier constant internally.
// PARAMETERS
//  IDENTIFIER  8'hD3    constant ID byte, sent first (frame bits 39..32)
//  BIT_PERIOD  36       clocks per transmitted bit (>=2)
//  LEVEL_HIGH  10'd768  sample for a '1' (must be >512)
//  LEVEL_LOW   10'd256  sample for a '0' (must be <512)
//  LEVEL_IDLE  10'd512  sample when not transmitting
// PORTS
//  clock         in   1   single system clock, all logic on rising edge
//  reset_n       in   1   synchronous, active-low reset
//  enable        in   1   1 = run; 0 = freeze divider/shifter, output idle
//  load          in   1   rising edge (with enable=1) starts a new frame
//  sequence      in   32  payload, captured at the load edge
//  sequence_out  out  10  registered level sample
//  busy          out  1   1 while a frame is being sent
// BEHAVIOUR
//  Reset: reset_n=0 at an edge -> sequence_out=LEVEL_IDLE, busy=0, divider=0, bit count=0, shift reg=0, load history=0.
//  Load detect:
//   - load_q registers load every cycle, including when enable=0.
//   - Start condition: enable & load & ~load_q.
//   - Holding load high for many cycles starts exactly one frame.
//  Start: shift_reg<={IDENTIFIER,sequence}; divider<=0; bitcnt<=0; busy<=1.
//   - The next cycle sequence_out shows the level of frame bit 39 (1-cycle latency).
//   - A start while busy aborts the current frame and restarts cleanly.
//  Running (busy=1, enable=1):
//   - divider counts 0..BIT_PERIOD-1.
//   - When divider==BIT_PERIOD-1: divider<=0, shift_reg<<=1, bitcnt++.
//   - When bitcnt reaches 39 at that point: busy<=0 instead, and the output returns to LEVEL_IDLE the next cycle.
//  Output: sequence_out <= busy ? (shift_reg[39] ? LEVEL_HIGH : LEVEL_LOW) : LEVEL_IDLE.
//   - Each bit is held for exactly BIT_PERIOD cycles.
//   - A busy frame never emits 512.
//  enable=0: divider, bitcnt and shift_reg hold; sequence_out=LEVEL_IDLE the next cycle. Re-enabling resumes mid-bit, continuing where it stopped.
//  Frame length: 40*BIT_PERIOD cycles (1440 at default).
//  Clock cycle 1 = first edge with the load edge; bit k (k=39..0) is output during cycles 2+(39-k)*36 .. 37+(39-k)*36.
//  Reset mid-frame: idle immediately (next cycle), frame discarded.
// TESTING
//  1. Reset -> sequence_out=512, busy=0; held 100 cycles with load=0.
//  2. enable=1, sequence=32'hAA, load high for 36 clocks then low.
//     - Slice at clock 17 of each 36-clock window -> recovered 40 bits = {8'hD3, 32'h000000AA}.
//     - Never 512 during the frame.
//  3. Same frame, check bit edges:
//     - Level changes only on cycles 2+36n.
//     - busy falls and output returns to 512 after cycle 1441.
//  4. Drop enable for 50 clocks in the middle of bit 20:
//     - Output 512 while low.
//     - On resume, bit 20 completes its remaining cycles, then bits 19..0 are correct.
//  5. Second load edge at bit 10 with sequence=32'hFFFF0000 -> frame restarts, {D3,FFFF0000} sent in full.
//  6. Assert reset_n=0 mid-frame -> next cycle 512, busy=0; load held high across reset release does not start a frame.

Source files
------------

// File: rtl/scramble_id_sequence_emitter_if.sv
// Handshake/bus bundle between the scrambler key source and the ID sequence emitter.
// Master drives enable/load/sequence; the emitter answers with the level sample and busy.
interface scramble_id_sequence_emitter_if;
    logic        i_enable;
    logic        i_load;
    logic [31:0] i_sequence;
    logic [9:0]  o_sequence_out;
    logic        o_busy;

    modport master (
        output i_enable,
        output i_load,
        output i_sequence,
        input  o_sequence_out,
        input  o_busy
    );

    modport slave (
        input  i_enable,
        input  i_load,
        input  i_sequence,
        output o_sequence_out,
        output o_busy
    );
endinterface

// File: rtl/scramble_id_sequence_emitter.sv
// Serialises {IDENTIFIER, sequence} MSB first as 10-bit levels, BIT_PERIOD clocks per bit.
// One-cycle latency from the load edge to the first level; enable=0 freezes the frame and idles the output.
module scramble_id_sequence_emitter #(
    parameter logic [7:0] IDENTIFIER = 8'hD3,
    parameter int         BIT_PERIOD = 36,
    parameter logic [9:0] LEVEL_HIGH = 10'd768,
    parameter logic [9:0] LEVEL_LOW  = 10'd256,
    parameter logic [9:0] LEVEL_IDLE = 10'd512
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    scramble_id_sequence_emitter_if.slave bus
);
    localparam int DIV_W = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_PERIOD - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [5:0]       r_bitcnt;
    logic [5:0]       w_bitcnt_nxt;
    logic [39:0]      r_shift;
    logic [39:0]      w_shift_nxt;
    logic [9:0]       r_out;
    logic [9:0]       w_out_nxt;
    logic             r_load_q;
    logic             r_armed;
    logic             w_start;

    // r_armed requires load to be seen low after reset, so a load held high
    // across reset release is not mistaken for a fresh rising edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_div_nxt    = r_div;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_out_nxt    = LEVEL_IDLE;
        w_start      = bus.i_enable & bus.i_load & ~r_load_q & r_armed;

        if ((r_state == ST_SEND) && bus.i_enable) begin
            w_out_nxt = r_shift[39] ? LEVEL_HIGH : LEVEL_LOW;
        end

        if (w_start) begin
            w_shift_nxt  = {IDENTIFIER, bus.i_sequence};
            w_div_nxt    = '0;
            w_bitcnt_nxt = '0;
            w_state_nxt  = ST_SEND;
        end else if ((r_state == ST_SEND) && bus.i_enable) begin
            if (r_div == DIV_LAST) begin
                w_div_nxt = '0;
                if (r_bitcnt == 6'd39) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_shift_nxt  = r_shift << 1;
                    w_bitcnt_nxt = r_bitcnt + 6'd1;
                end
            end else begin
                w_div_nxt = r_div + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_out    <= LEVEL_IDLE;
            r_load_q <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_div    <= w_div_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_out    <= w_out_nxt;
            r_load_q <= bus.i_load;
            r_armed  <= r_armed | ~bus.i_load;
        end
    end

    assign bus.o_sequence_out = r_out;
    assign bus.o_busy         = (r_state == ST_SEND);
endmodule

// File: tb/tb_scramble_id_sequence_emitter.sv
// Bench for scramble_id_sequence_emitter: directed frame scenarios plus random traffic,
// checked every cycle against a bit-timeline reference model.
module tb_scramble_id_sequence_emitter;
    localparam int         BP   = 36;
    localparam logic [9:0] LV_H = 10'd768;
    localparam logic [9:0] LV_L = 10'd256;
    localparam logic [9:0] LV_I = 10'd512;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scramble_id_sequence_emitter_if bus();

    scramble_id_sequence_emitter dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a frame is a 40-bit word plus a count of enabled cycles elapsed.
    bit [39:0]  m_frame   = '0;
    int         m_elapsed = 0;
    bit         m_active  = 1'b0;
    bit         m_load_q  = 1'b0;
    bit         m_armed   = 1'b0;
    logic [9:0] m_out     = LV_I;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit start;
        @(posedge clk);
        if (!rst_n) begin
            m_out     = LV_I;
            m_active  = 1'b0;
            m_elapsed = 0;
            m_load_q  = 1'b0;
            m_armed   = 1'b0;
        end else begin
            m_out = (m_active && bus.i_enable) ?
                    (m_frame[39 - m_elapsed / BP] ? LV_H : LV_L) : LV_I;
            start    = bus.i_enable && bus.i_load && !m_load_q && m_armed;
            m_armed  = m_armed || !bus.i_load;
            m_load_q = bus.i_load;
            if (start) begin
                m_frame   = {8'hD3, bus.i_sequence};
                m_active  = 1'b1;
                m_elapsed = 0;
            end else if (m_active && bus.i_enable) begin
                m_elapsed++;
                if (m_elapsed == 40 * BP) m_active = 1'b0;
            end
        end
        #1;
        check_val("out_vs_model", 64'(bus.o_sequence_out), 64'(m_out));
        check_val("busy_vs_model", 64'(bus.o_busy), 64'(m_active));
    endtask

    initial begin
        bit [39:0]  rec;
        logic [9:0] prev;
        int         d;

        rst_n          = 1'b0;
        bus.i_enable   = 1'b0;
        bus.i_load     = 1'b0;
        bus.i_sequence = '0;
        repeat (3) tick();
        check_val("reset_out", 64'(bus.o_sequence_out), 64'(LV_I));
        check_val("reset_busy", 64'(bus.o_busy), 64'd0);

        // Idle hold after reset
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check_val("idle_out", 64'(bus.o_sequence_out), 64'(LV_I));
            check_val("idle_busy", 64'(bus.o_busy), 64'd0);
        end

        // Basic frame: slicing, level-change positions, end of frame
        bus.i_enable   = 1'b1;
        bus.i_sequence = 32'h0000_00AA;
        bus.i_load     = 1'b1;
        rec  = '0;
        prev = LV_I;
        for (int c = 1; c <= 1450; c++) begin
            tick();
            if (c == 36) bus.i_load = 1'b0;
            if (c >= 2 && c <= 1441)
                check_val("frame_never_idle", 64'(bus.o_sequence_out == LV_I), 64'd0);
            if (c >= 2 && c <= 1442 && bus.o_sequence_out !== prev)
                check_val("edge_cycle", 64'((c - 2) % BP), 64'd0);
            if (c >= 2 && c <= 1441 && (c - 2) % BP == 16)
                rec[39 - (c - 2) / BP] = (bus.o_sequence_out > LV_I);
            if (c == 1440) check_val("busy_before_end", 64'(bus.o_busy), 64'd1);
            if (c == 1441) check_val("busy_fall", 64'(bus.o_busy), 64'd0);
            if (c == 1442) check_val("idle_after_frame", 64'(bus.o_sequence_out), 64'(LV_I));
            prev = bus.o_sequence_out;
        end
        check_val("slice_aa", 64'(rec), 64'({8'hD3, 32'h0000_00AA}));

        // Enable dropped for 50 clocks in the middle of bit 20
        bus.i_sequence = $urandom;
        bus.i_load     = 1'b1;
        for (int c = 1; c <= 1500; c++) begin
            tick();
            if (c == 1) bus.i_load = 1'b0;
            if (c == 699) bus.i_enable = 1'b0;
            if (c == 749) bus.i_enable = 1'b1;
            if (c >= 700 && c <= 749)
                check_val("en_low_idle", 64'(bus.o_sequence_out), 64'(LV_I));
            if (c == 1490) check_val("stretched_busy", 64'(bus.o_busy), 64'd1);
            if (c == 1491) check_val("stretched_end", 64'(bus.o_busy), 64'd0);
        end

        // Restart at bit 10 with a new payload
        bus.i_sequence = $urandom;
        bus.i_load     = 1'b1;
        rec = '0;
        for (int c = 1; c <= 2510; c++) begin
            tick();
            if (c == 1) bus.i_load = 1'b0;
            if (c == 1059) begin
                bus.i_sequence = 32'hFFFF_0000;
                bus.i_load     = 1'b1;
            end
            if (c == 1060) bus.i_load = 1'b0;
            d = c - 1059;
            if (d >= 2 && d <= 1441 && (d - 2) % BP == 16)
                rec[39 - (d - 2) / BP] = (bus.o_sequence_out > LV_I);
            if (d == 1441) check_val("restart_end", 64'(bus.o_busy), 64'd0);
        end
        check_val("slice_ffff0000", 64'(rec), 64'({8'hD3, 32'hFFFF_0000}));

        // Reset mid-frame with load held high across release
        bus.i_sequence = $urandom;
        bus.i_load     = 1'b1;
        tick();
        bus.i_load = 1'b0;
        repeat (300) tick();
        bus.i_load = 1'b1;
        rst_n      = 1'b0;
        tick();
        check_val("reset_mid_out", 64'(bus.o_sequence_out), 64'(LV_I));
        check_val("reset_mid_busy", 64'(bus.o_busy), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check_val("no_start_held_load", 64'(bus.o_busy), 64'd0);
        end
        bus.i_load = 1'b0;
        tick();
        bus.i_load = 1'b1;
        tick();
        check_val("start_after_release", 64'(bus.o_busy), 64'd1);
        bus.i_load = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.i_enable   = ($urandom_range(0, 19) != 0);
            bus.i_load     = ($urandom_range(0, 199) == 0) ? 1'b1
                           : (bus.i_load && ($urandom_range(0, 3) != 0));
            bus.i_sequence = $urandom;
            rst_n          = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
